// File: rtl/mod3_tx_pkg.sv
// mod3_tx_pkg: shared definitions for the divisible-by-3 frame transmitter.
//   state_t  : FSM encoding (IDLE, DATA, CHK, PRE)
//   RES_W    : width of the mod-3 residue
//   chk_bits : residue after the last data bit -> 2 check bits that make the
//              whole frame value a multiple of three
package mod3_tx_pkg;

  localparam int unsigned RES_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    CHK  = 2'b10,
    PRE  = 2'b11
  } state_t;

  // Appending c shifts the payload left by two (x4 == x1 mod 3), so c must
  // equal (3 - r) mod 3: r=1 -> 2, r=2 -> 1, r=0 -> 0.
  function automatic logic [1:0] chk_bits(input logic [RES_W-1:0] r);
    logic [1:0] c;
    case (r)
      2'd0:    c = 2'b00;
      2'd1:    c = 2'b10;
      2'd2:    c = 2'b01;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mod3_residue_tracker.sv
// mod3_residue_tracker: running value mod 3 of an MSB-first bit stream.
//   clk, rst  : clock, synchronous active-high reset (residue -> 0)
//   clr       : restart the stream (residue -> 0)
//   en        : data_bit is part of the stream this cycle
//   data_bit  : incoming stream bit
//   residue   : (value so far) mod 3, always in {0,1,2}
module mod3_residue_tracker
  import mod3_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             data_bit,
  output logic [RES_W-1:0] residue
);

  // r' = (2r + b) mod 3, tabulated so no intermediate exceeds 2 bits.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      residue <= '0;
    end else if (en) begin
      case (residue)
        2'd0:    residue <= {1'b0, data_bit};
        2'd1:    residue <= data_bit ? 2'd0 : 2'd2;
        2'd2:    residue <= data_bit ? 2'd2 : 2'd1;
        default: residue <= '0;
      endcase
    end
  end

endmodule

// File: rtl/mod3_frame_tx.sv
// mod3_frame_tx: sends a DATA_W-bit word MSB-first followed by two check
// bits so that the serial frame, read as a binary number, is divisible by 3.
//   clk, rst  : clock, synchronous active-high reset (aborts any frame)
//   ld_valid  : producer offers ld_data
//   ld_data   : payload word
//   ld_ready  : word accepted this cycle (IDLE and not in reset)
//   tx_bit    : serial bit (0 when tx_valid is low)
//   tx_valid  : tx_bit belongs to a frame
//   tx_first  : first bit of a frame
//   tx_last   : final check bit of a frame
//   busy      : frame in progress (state != IDLE)
// Build option MOD3_TX_PREAMBLE_EN: prefix each frame with one '0' start bit.
module mod3_frame_tx
  import mod3_tx_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_first,
  output logic              tx_last,
  output logic              busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef MOD3_TX_PREAMBLE_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;
  logic              chk_sec;
  logic [RES_W-1:0]  residue;
  logic [1:0]        c;
  logic              take;

  assign ld_ready = (state == IDLE) && !rst;
  assign take     = ld_valid && ld_ready;
  assign busy     = (state != IDLE);
  assign c        = chk_bits(residue);

  // Residue advances on the same edge a data bit is registered onto tx_bit,
  // so it is final when CHK starts.
  mod3_residue_tracker u_res (
    .clk      (clk),
    .rst      (rst),
    .clr      (take),
    .en       (state == DATA),
    .data_bit (sreg[DATA_W-1]),
    .residue  (residue)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      chk_sec  <= 1'b0;
      tx_bit   <= 1'b0;
      tx_valid <= 1'b0;
      tx_first <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      tx_bit   <= 1'b0;
      tx_valid <= 1'b0;
      tx_first <= 1'b0;
      tx_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            sreg    <= ld_data;
            cnt     <= CNT_W'(DATA_W - 1);
            chk_sec <= 1'b0;
`ifdef MOD3_TX_PREAMBLE_EN
            state   <= PRE;
`else
            state   <= DATA;
`endif
          end
        end
        PRE: begin
`ifdef MOD3_TX_PREAMBLE_EN
          tx_valid <= 1'b1;
          tx_first <= 1'b1;
          state    <= DATA;
`else
          state    <= IDLE;
`endif
        end
        DATA: begin
          tx_bit   <= sreg[DATA_W-1];
          tx_valid <= 1'b1;
          tx_first <= !PRE_EN && (cnt == CNT_W'(DATA_W - 1));
          sreg     <= sreg << 1;
          if (cnt == '0) begin
            state <= CHK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CHK: begin
          tx_valid <= 1'b1;
          if (!chk_sec) begin
            tx_bit  <= c[1];
            chk_sec <= 1'b1;
          end else begin
            tx_bit  <= c[0];
            tx_last <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
